verifier_check_v_late: RTL and testbench

Verifier-side counterpart of the prover's late-phase V computation. For each of the `2*ninbits` sumcheck rounds it consumes the prover's round-polynomial coefficients `c[2:0]` and checks `p(0)+p(1)` against the running claim. It then draws a random challenge `tau` from the RNG and drives `tau` and `m_tau_p1` back to the prover. Finally it advances the claim to `p(tau)`. It sits between the sumcheck coefficient channel and the per-layer final check.

---
 rtl/verifier_check_v_late_pkg.sv | 35 +++
 rtl/verifier_check_v_late_poly_eval.sv | 64 ++++++
 rtl/verifier_check_v_late.sv | 148 ++++++++++++++
 tb/tb_verifier_check_v_late.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/verifier_check_v_late_pkg.sv
// Shared field constants, FSM state encoding and modular add/sub helpers for
// the late-phase V sumcheck verifier.
package verifier_check_v_late_pkg;

    localparam int F_NBITS = 61;
    // Mersenne prime 2^61-1; the multiplier's folding reduction relies on this form.
    localparam logic [F_NBITS-1:0] F_PRIME = {F_NBITS{1'b1}};
    localparam logic [F_NBITS-1:0] F_ONE   = {{(F_NBITS-1){1'b0}}, 1'b1};

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_CHECK   = 3'd1;
    localparam state_t ST_RNG     = 3'd2;
    localparam state_t ST_MUL1_ST = 3'd3;
    localparam state_t ST_MUL1    = 3'd4;
    localparam state_t ST_MUL2_ST = 3'd5;
    localparam state_t ST_MUL2    = 3'd6;

    function automatic logic [F_NBITS-1:0] mod_add(input logic [F_NBITS-1:0] a,
                                                   input logic [F_NBITS-1:0] b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, F_PRIME}) s = s - {1'b0, F_PRIME};
        return s[F_NBITS-1:0];
    endfunction

    function automatic logic [F_NBITS-1:0] mod_sub(input logic [F_NBITS-1:0] a,
                                                   input logic [F_NBITS-1:0] b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, F_PRIME} - {1'b0, b};
        if (s >= {1'b0, F_PRIME}) s = s - {1'b0, F_PRIME};
        return s[F_NBITS-1:0];
    endfunction

endpackage

// File: rtl/verifier_check_v_late_poly_eval.sv
// Horner evaluation of p(tau)=c0+tau*(c1+tau*c2) over one shared field multiplier.
// Each en pulse runs the next Horner step; ready pulses once per completed step.
module verifier_poly_eval
    import verifier_check_v_late_pkg::*;
(
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      en,
    input  logic [2:0][F_NBITS-1:0]   c,
    input  logic [F_NBITS-1:0]        tau,
    output logic                      ready,
    output logic [F_NBITS-1:0]        result
);

    logic                 step;
    logic                 busy;
    logic [F_NBITS-1:0]   op_a;
    logic [F_NBITS-1:0]   op_b;
    logic [F_NBITS-1:0]   t_reg;
    logic [F_NBITS-1:0]   prod_red;

    // x = hi*2^61 + lo is congruent to hi + lo; two folds and one subtract land below p.
    function automatic logic [F_NBITS-1:0] mersenne_reduce(input logic [2*F_NBITS-1:0] x);
        logic [F_NBITS:0] fold;
        logic [F_NBITS:0] fold2;
        fold  = {1'b0, x[2*F_NBITS-1:F_NBITS]} + {1'b0, x[F_NBITS-1:0]};
        fold2 = {1'b0, fold[F_NBITS-1:0]} + {{F_NBITS{1'b0}}, fold[F_NBITS]};
        if (fold2 >= {1'b0, F_PRIME}) fold2 = fold2 - {1'b0, F_PRIME};
        return fold2[F_NBITS-1:0];
    endfunction

    assign prod_red = mersenne_reduce({{F_NBITS{1'b0}}, op_a} * {{F_NBITS{1'b0}}, op_b});

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            step   <= 1'b0;
            busy   <= 1'b0;
            ready  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            t_reg  <= '0;
            result <= '0;
        end else begin
            ready <= 1'b0;
            if (en && !busy) begin
                op_a <= tau;
                op_b <= step ? mod_add(c[1], t_reg) : c[2];
                busy <= 1'b1;
            end else if (busy) begin
                busy  <= 1'b0;
                ready <= 1'b1;
                if (step) begin
                    result <= mod_add(c[0], prod_red);
                    step   <= 1'b0;
                end else begin
                    t_reg  <= prod_red;
                    result <= prod_red;
                    step   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/verifier_check_v_late.sv
// Late-phase V sumcheck verifier: per-round p(0)+p(1) check, challenge draw, claim update.
// Optional build macro VERIFIER_V_LATE_ABORT_EN ends the sumcheck on the first mismatch.
module verifier_check_v_late
    import verifier_check_v_late_pkg::*;
#(
    parameter int ninputs = 8,
    parameter int ninbits = $clog2(ninputs)
)
(
    input  logic                               clk,
    input  logic                               rstb,
    input  logic                               en,
    input  logic                               restart,
    input  logic [F_NBITS-1:0]                 claim_in,
    input  logic [2:0][F_NBITS-1:0]            c_in,
    input  logic [F_NBITS-1:0]                 h0_in,
    input  logic [F_NBITS-1:0]                 h1_in,
    output logic                               rng_req,
    input  logic                               rng_valid,
    input  logic [F_NBITS-1:0]                 rng_in,
    output logic [F_NBITS-1:0]                 tau,
    output logic [F_NBITS-1:0]                 m_tau_p1,
    output logic [F_NBITS-1:0]                 claim_out,
    output logic [F_NBITS-1:0]                 h0_out,
    output logic [F_NBITS-1:0]                 h1_out,
    output logic [$clog2(2*ninbits+1)-1:0]     round,
    output logic                               ready,
    output logic                               ready_pulse,
    output logic                               done,
    output logic                               fail,
    output logic [2:0]                         fsm_state
);

    localparam int RW = $clog2(2*ninbits+1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(2*ninbits);

    generate
        if (ninbits != $clog2(ninputs)) begin : g_bad_ninbits
            $error("ninbits is derived from ninputs and must not be overridden");
        end
    endgenerate

    state_t                    state;
    logic                      en_dly;
    logic                      idle_d;
    logic                      start;
    logic                      sum_ok;
    logic [2:0][F_NBITS-1:0]   c_reg;
    logic [F_NBITS-1:0]        claim_reg;
    logic                      poly_en;
    logic                      poly_ready;
    logic [F_NBITS-1:0]        poly_result;
    logic [RW-1:0]             round_nxt;

    assign start     = en & ~en_dly;
    assign ready     = (state == ST_IDLE) & ~start;
    assign rng_req   = (state == ST_RNG);
    assign poly_en   = (state == ST_MUL1_ST) | (state == ST_MUL2_ST);
    assign sum_ok    = (mod_add(mod_add(c_reg[0], c_reg[0]), mod_add(c_reg[1], c_reg[2])) == claim_reg);
    assign round_nxt = round + RW'(1);
    assign claim_out = claim_reg;
    assign fsm_state = state;

    verifier_poly_eval u_poly_eval (
        .clk    (clk),
        .rstb   (rstb),
        .en     (poly_en),
        .c      (c_reg),
        .tau    (tau),
        .ready  (poly_ready),
        .result (poly_result)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= ST_IDLE;
            en_dly      <= 1'b1;
            idle_d      <= 1'b1;
            ready_pulse <= 1'b0;
            c_reg       <= '0;
            claim_reg   <= '0;
            tau         <= '0;
            m_tau_p1    <= '0;
            h0_out      <= '0;
            h1_out      <= '0;
            round       <= '0;
            done        <= 1'b0;
            fail        <= 1'b0;
        end else begin
            en_dly      <= en;
            idle_d      <= (state == ST_IDLE);
            ready_pulse <= (state == ST_IDLE) & ~idle_d;
            case (state)
                ST_IDLE: begin
                    // A finished sumcheck only accepts a start that also restarts it.
                    if (start && (restart || !done)) begin
                        c_reg <= c_in;
                        if (restart) begin
                            claim_reg <= claim_in;
                            round     <= '0;
                            done      <= 1'b0;
                            fail      <= 1'b0;
                        end
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
`ifdef VERIFIER_V_LATE_ABORT_EN
                    if (!sum_ok) begin
                        fail  <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_RNG;
                    end
`else
                    if (!sum_ok) fail <= 1'b1;
                    state <= ST_RNG;
`endif
                end
                ST_RNG: begin
                    if (rng_valid) begin
                        tau      <= rng_in;
                        m_tau_p1 <= mod_sub(F_ONE, rng_in);
                        state    <= ST_MUL1_ST;
                    end
                end
                ST_MUL1_ST: state <= ST_MUL1;
                ST_MUL1:    if (poly_ready) state <= ST_MUL2_ST;
                ST_MUL2_ST: state <= ST_MUL2;
                ST_MUL2: begin
                    if (poly_ready) begin
                        claim_reg <= poly_result;
                        round     <= round_nxt;
                        if (round_nxt == LAST_ROUND) begin
                            h0_out <= h0_in;
                            h1_out <= h1_in;
                            done   <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_verifier_check_v_late.sv
// Randomized bench for verifier_check_v_late against a direct polynomial-evaluation model.
module tb_verifier_check_v_late;
    import verifier_check_v_late_pkg::*;

    localparam logic [63:0] P = 64'h1FFF_FFFF_FFFF_FFFF;

    logic                     clk = 1'b0;
    logic                     rstb = 1'b0;
    logic                     en = 1'b0;
    logic                     restart = 1'b0;
    logic [60:0]              claim_in = '0;
    logic [2:0][60:0]         c_in = '0;
    logic [60:0]              h0_in = '0;
    logic [60:0]              h1_in = '0;
    logic                     rng_req;
    logic                     rng_valid = 1'b0;
    logic [60:0]              rng_in = '0;
    logic [60:0]              tau;
    logic [60:0]              m_tau_p1;
    logic [60:0]              claim_out;
    logic [60:0]              h0_out;
    logic [60:0]              h1_out;
    logic [2:0]               round;
    logic                     ready;
    logic                     ready_pulse;
    logic                     done;
    logic                     fail;
    logic [2:0]               fsm_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_q[$];
    logic [63:0] m_claim = 0;
    logic [63:0] m_h0 = 0;
    logic [63:0] m_h1 = 0;
    int          m_round = 0;
    bit          m_done = 0;
    bit          m_fail = 0;

    always #5 clk = ~clk;

    verifier_check_v_late dut (
        .clk         (clk),
        .rstb        (rstb),
        .en          (en),
        .restart     (restart),
        .claim_in    (claim_in),
        .c_in        (c_in),
        .h0_in       (h0_in),
        .h1_in       (h1_in),
        .rng_req     (rng_req),
        .rng_valid   (rng_valid),
        .rng_in      (rng_in),
        .tau         (tau),
        .m_tau_p1    (m_tau_p1),
        .claim_out   (claim_out),
        .h0_out      (h0_out),
        .h1_out      (h1_out),
        .round       (round),
        .ready       (ready),
        .ready_pulse (ready_pulse),
        .done        (done),
        .fail        (fail),
        .fsm_state   (fsm_state)
    );

    function automatic logic [63:0] f_add(input logic [63:0] a, input logic [63:0] b);
        return (a + b) % P;
    endfunction

    function automatic logic [63:0] f_sub(input logic [63:0] a, input logic [63:0] b);
        return (a + P - b) % P;
    endfunction

    function automatic logic [63:0] f_mul(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] x;
        x = {64'b0, a} * {64'b0, b};
        x = x % {64'b0, P};
        return x[63:0];
    endfunction

    function automatic logic [63:0] f_rand();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r % P;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_tau", tau, 0);
        check("rst_m_tau_p1", m_tau_p1, 0);
        check("rst_claim", claim_out, 0);
        check("rst_h0", h0_out, 0);
        check("rst_h1", h1_out, 0);
        check("rst_round", 64'(round), 0);
        check("rst_ready", ready, 1);
        check("rst_ready_pulse", ready_pulse, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_rng_req", rng_req, 0);
    endtask

    // Coefficients whose p(0)+p(1) equals the given claim.
    task automatic gen_ok(input logic [63:0] cl, input bit near_p,
                          output logic [63:0] c0, output logic [63:0] c1, output logic [63:0] c2);
        if (near_p) begin
            c0 = P - 1 - 64'($urandom_range(0, 5));
            c1 = P - 2;
        end else begin
            c0 = f_rand();
            c1 = f_rand();
        end
        c2 = f_sub(cl, f_add(f_add(c0, c0), c1));
    endtask

    task automatic run_round(input bit rs, input logic [63:0] cl,
                             input logic [63:0] c0, input logic [63:0] c1, input logic [63:0] c2,
                             input logic [63:0] r, input int wait_n, input bit stray);
        logic [63:0] h0v;
        logic [63:0] h1v;
        int cnt;
        int pulses;
        bit req_ok;
        h0v = f_rand();
        h1v = f_rand();
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        restart  = rs;
        claim_in = cl[60:0];
        c_in[0]  = c0[60:0];
        c_in[1]  = c1[60:0];
        c_in[2]  = c2[60:0];
        h0_in    = h0v[60:0];
        h1_in    = h1v[60:0];
        en       = 1'b1;
        #1 check("ready_drop_on_start", ready, 0);

        if (rs) begin
            m_claim = cl; m_round = 0; m_done = 0; m_fail = 0;
        end
        if (f_add(f_add(c0, c0), f_add(c1, c2)) != m_claim) m_fail = 1;
        m_claim = f_add(c0, f_add(f_mul(c1, r), f_mul(c2, f_mul(r, r))));
        m_round++;
        if (m_round == 6) begin
            m_done = 1; m_h0 = h0v; m_h1 = h1v;
        end
        exp_q.push_back(m_claim);

        @(negedge clk);
        en = 1'b0;
        restart = 1'b0;
        check("rng_req_in_check", rng_req, 0);
        @(negedge clk);
        check("rng_req_rise", rng_req, 1);
        req_ok = 1;
        for (int i = 0; i < wait_n; i++) begin
            @(negedge clk);
            if (!rng_req) req_ok = 0;
        end
        if (wait_n > 0) check("rng_req_hold", req_ok, 1);
        rng_in = r[60:0];
        rng_valid = 1'b1;
        @(negedge clk);
        rng_valid = 1'b0;
        rng_in = f_rand()[60:0];
        check("tau", tau, r);
        check("m_tau_p1", m_tau_p1, f_sub(1, r));

        cnt = 0;
        pulses = 0;
        while (!ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (ready_pulse) pulses++;
        end
        check("round_completes", ready, 1);
        check("claim_out", claim_out, exp_q.pop_front());
        check("round", 64'(round), 64'(m_round));
        check("done", done, m_done);
        check("fail", fail, m_fail);
        check("h0_out", h0_out, m_h0);
        check("h1_out", h1_out, m_h1);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ready_pulse) pulses++;
            if (stray) begin
                rng_valid = (i == 0);
                rng_in = f_rand()[60:0];
            end
        end
        rng_valid = 1'b0;
        check("ready_pulse_once", 64'(pulses), 1);
        check("tau_stable", tau, r);
        check("claim_stable", claim_out, m_claim);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] c0, c1, c2, r;
        bit ok;
        int cnt;

        en = 1'b1;
        rstb = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rstb = 1'b1;
        ok = 1;
        repeat (5) begin
            @(negedge clk);
            if (!ready || rng_req) ok = 0;
        end
        check("no_start_en_held_through_reset", ok, 1);

        run_round(1, 10, 1, 2, 3, f_rand(), 0, 0);

        run_round(1, 7, 1, 2, 3, 5, 0, 0);
        check("example_claim_86", claim_out, 86);
        check("example_m_tau_p1", m_tau_p1, P - 4);

        for (int k = 2; k <= 6; k++) begin
            gen_ok(m_claim, (k == 4), c0, c1, c2);
            r = (k == 2) ? 64'd0 : (k == 3) ? 64'd1 : f_rand();
            run_round(0, 0, c0, c1, c2, r,
                      (k == 5) ? 20 : int'($urandom_range(0, 3)), (k == 5));
            if (k == 2) check("tau0_claim_is_c0", claim_out, c0);
            if (k == 3) check("tau1_claim_is_sum", claim_out, f_add(c0, f_add(c1, c2)));
        end

        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        restart = 1'b0;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        ok = 1;
        repeat (6) begin
            @(negedge clk);
            if (rng_req || !ready) ok = 0;
        end
        check("start_after_done_ignored", ok, 1);
        check("round_after_ignored", 64'(round), 6);
        check("claim_after_ignored", claim_out, m_claim);

        gen_ok(64'd1234, 0, c0, c1, c2);
        @(negedge clk);
        restart  = 1'b1;
        claim_in = 61'd1234;
        c_in[0]  = c0[60:0];
        c_in[1]  = c1[60:0];
        c_in[2]  = c2[60:0];
        en = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        cnt = 0;
        while (!rng_req && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        rng_valid = 1'b1;
        rng_in = f_rand()[60:0];
        @(negedge clk);
        rng_valid = 1'b0;
        cnt = 0;
        while (fsm_state != ST_MUL2 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("reach_mul2", 64'(fsm_state), 64'(ST_MUL2));
        rstb = 1'b0;
        #1 check_reset_values();
        @(negedge clk);
        rstb = 1'b1;
        ok = 1;
        repeat (5) begin
            @(negedge clk);
            if (!ready || rng_req) ok = 0;
        end
        check("no_start_en_held_after_midreset", ok, 1);
        m_claim = 0; m_round = 0; m_done = 0; m_fail = 0; m_h0 = 0; m_h1 = 0;

        r = f_rand();
        gen_ok(r, 0, c0, c1, c2);
        run_round(1, r, c0, c1, c2, f_rand(), int'($urandom_range(0, 4)), 1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
